// File: rtl/btn_debounce_multi_pkg.sv
// Shared types for the multi-channel push-button debouncer.
// Channel FSM encoding: IDLE=00, PRESS_WAIT=01, STABLE=11, RELEASE_WAIT=10.
package btn_debounce_multi_pkg;

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_DEB_CYCLES  = 100;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_LONG_CYCLES = 1000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_STABLE       = 2'b11,
    ST_RELEASE_WAIT = 2'b10
  } deb_state_e;

  // Registered per-channel result bundle
  typedef struct packed {
    logic level;
    logic press;
    logic release_ev;
    logic long_press;
  } ch_out_t;

  // Debounced level implied by a state: high while accepted-pressed
  function automatic logic is_high_state(deb_state_e s);
    return (s == ST_STABLE) || (s == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce_multi_ch.sv
// One debouncer channel: synchroniser, press/release filter FSM, optional hold timer.
// Optional feature: BTN_DEBOUNCE_LONG_PRESS_EN enables the long-press pulse.
module btn_debounce_multi_ch
  import btn_debounce_multi_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    btn,
  output ch_out_t out,
  output logic    level_nxt_c
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  // Elaboration-time sanity on configuration
  if (DEB_CYCLES < 2)  begin : g_bad_deb  $error("DEB_CYCLES must be >= 2");  end
  if (SYNC_STAGES < 2) begin : g_bad_sync $error("SYNC_STAGES must be >= 2"); end
  if (LONG_CYCLES < 2) begin : g_bad_long $error("LONG_CYCLES must be >= 2"); end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_d, press_d, release_d, long_d;

  // Input synchroniser shift chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // State and filter counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: any bounce in a WAIT state falls back to the previous stable state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the transition being taken
  always_comb begin
    level_d   = is_high_state(state_d);
    press_d   = (state_q == ST_PRESS_WAIT)   && (state_d == ST_STABLE);
    release_d = (state_q == ST_RELEASE_WAIT) && (state_d == ST_IDLE);
  end

  assign level_nxt_c = level_d;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q;
  logic              long_done_q;

  // Hold timer: runs only in STABLE, saturates; one pulse per accepted press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      long_done_q <= 1'b0;
    end else begin
      if (state_q == ST_STABLE) begin
        if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
      end else begin
        hold_q <= '0;
      end
      if (state_q == ST_IDLE) long_done_q <= 1'b0;
      else if (long_d)        long_done_q <= 1'b1;
    end
  end

  // Long-press fires once the hold timer has saturated
  always_comb begin
    long_d = (state_q == ST_STABLE) && (hold_q == HOLD_MAX) && !long_done_q;
  end
`else
  // Long-press feature absent
  always_comb begin
    long_d = 1'b0;
  end
`endif

  // Registered channel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out.level      <= level_d;
      out.press      <= press_d;
      out.release_ev <= release_d;
      out.long_press <= long_d;
    end
  end

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button debouncer top: per-channel filters plus registered any_level.
// Optional feature: define BTN_DEBOUNCE_LONG_PRESS_EN for long-press pulses on long_p.
module btn_debounce_multi
  import btn_debounce_multi_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_p,
  output logic            any_level
);

  ch_out_t         ch_out [N_CH];
  logic [N_CH-1:0] level_nxt;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    btn_debounce_multi_ch #(
      .DEB_CYCLES  (DEB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn         (btn[g]),
      .out         (ch_out[g]),
      .level_nxt_c (level_nxt[g])
    );

    assign level[g]     = ch_out[g].level;
    assign press_p[g]   = ch_out[g].press;
    assign release_p[g] = ch_out[g].release_ev;
    assign long_p[g]    = ch_out[g].long_press;
  end

  // any_level taken from next-state levels so it lines up with level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_level <= 1'b0;
    else        any_level <= |level_nxt;
  end

endmodule
